y_div_seq: RTL and testbench

//   Multi-cycle restoring divider: q = a / b, r = a % b. It is the inverse

---
 rtl/y_div_pkg.sv | 15 +
 rtl/y_div_step.sv | 26 ++
 rtl/y_div_seq.sv | 149 ++++++++++++++
 tb/tb_y_div_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/y_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package y_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_W_DEF = 32;

  // Quotient reported for a zero divisor.
  localparam logic [DIV_W_DEF-1:0] DZ_QUOT = {DIV_W_DEF{1'b1}};

endpackage

// File: rtl/y_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, and keep the difference only when it does not go negative.
module y_div_step
  import y_div_pkg::*;
#(
  parameter int W = DIV_W_DEF
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] dvd,
  input  logic [W-1:0] b,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] dvd_next,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] trial;

  // The full remainder is kept in the shift so divisors above 2^(W-1) work.
  assign shifted  = {rem, dvd[W-1]};
  assign trial    = shifted - {1'b0, b};
  assign q_bit    = ~trial[W];
  assign rem_next = q_bit ? trial[W-1:0] : shifted[W-1:0];
  assign dvd_next = {dvd[W-2:0], q_bit};

endmodule

// File: rtl/y_div_seq.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Optional signed (truncating) mode is enabled with the SIGNED_DIV_EN macro.
module y_div_seq
  import y_div_pkg::*;
#(
  parameter int W = DIV_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
`ifdef SIGNED_DIV_EN
  input  logic         sgn,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         dz
);

  localparam int            CW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg;
  logic [W-1:0]   rem_reg, dvd_reg, b_reg;
  logic [W-1:0]   q_reg, r_reg;
  logic           dz_reg;
  logic           neg_q_reg, neg_r_reg;

  logic [W-1:0]   a_mag, b_mag;
  logic           neg_q_next, neg_r_next;
  logic [W-1:0]   rem_step, dvd_step;
  logic           q_bit;
  logic [W-1:0]   q_final, q_res, r_res;
  logic           last;

`ifdef SIGNED_DIV_EN
  logic neg_a, neg_b;
  always_comb begin
    neg_a      = sgn & a[W-1];
    neg_b      = sgn & b[W-1];
    a_mag      = neg_a ? (~a + 1'b1) : a;
    b_mag      = neg_b ? (~b + 1'b1) : b;
    neg_q_next = neg_a ^ neg_b;
    neg_r_next = neg_a;
  end
`else
  always_comb begin
    a_mag      = a;
    b_mag      = b;
    neg_q_next = 1'b0;
    neg_r_next = 1'b0;
  end
`endif

  y_div_step #(.W(W)) u_step (
    .rem      (rem_reg),
    .dvd      (dvd_reg),
    .b        (b_reg),
    .rem_next (rem_step),
    .dvd_next (dvd_step),
    .q_bit    (q_bit)
  );

  assign last    = (cnt_reg == LAST);
  assign q_final = {dvd_reg[W-2:0], q_bit};
  // Sign fix-up is applied on the way into DONE, so latency is unaffected.
  assign q_res   = neg_q_reg ? (~q_final + 1'b1) : q_final;
  assign r_res   = neg_r_reg ? (~rem_step + 1'b1) : rem_step;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (b == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      rem_reg   <= '0;
      dvd_reg   <= '0;
      b_reg     <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      dz_reg    <= 1'b0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            cnt_reg   <= '0;
            rem_reg   <= '0;
            dvd_reg   <= a_mag;
            b_reg     <= b_mag;
            neg_q_reg <= neg_q_next;
            neg_r_reg <= neg_r_next;
            if (b == '0) begin
              q_reg  <= {W{DZ_QUOT[0]}};
              r_reg  <= a;
              dz_reg <= 1'b1;
            end
          end
        end
        CALC: begin
          rem_reg <= rem_step;
          dvd_reg <= dvd_step;
          cnt_reg <= cnt_reg + 1'b1;
          if (last) begin
            q_reg  <= q_res;
            r_reg  <= r_res;
            dz_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_reg == CALC);
  assign done = (state_reg == DONE);
  assign q    = q_reg;
  assign r    = r_reg;
  assign dz   = dz_reg;

endmodule

// File: tb/tb_y_div_seq.sv
// Scoreboard bench for y_div_seq; signed vectors run when SIGNED_DIV_EN is defined.
module tb_y_div_seq;

  localparam int W = 32;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, dz;
  logic [W-1:0] q, r;
`ifdef SIGNED_DIV_EN
  logic         sgn   = 1'b0;
`endif

  always #5 clk = ~clk;

  y_div_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SIGNED_DIV_EN
    .sgn   (sgn),
`endif
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dz    (dz)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int unsigned  done_cyc;
    int unsigned  busy_n;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  int unsigned busy_n = 0;
  exp_t        e;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_n = 0;
    end else begin
      if (busy) busy_n++;
      if (done) begin
        if (sb.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL spurious_done: got done=1 at cycle %0d required no done", cyc);
        end else begin
          e = sb.pop_front();
          $display("txn %s: q=%h r=%h dz=%0d cycle=%0d busy_cycles=%0d",
                   e.name, q, r, dz, cyc, busy_n);
          check({e.name, ".q"}, q, e.q);
          check({e.name, ".r"}, r, e.r);
          check({e.name, ".dz"}, {{(W-1){1'b0}}, dz}, {{(W-1){1'b0}}, e.dz});
          check({e.name, ".done_cycle"}, W'(cyc), W'(e.done_cyc));
          check({e.name, ".busy_cycles"}, W'(busy_n), W'(e.busy_n));
        end
        busy_n = 0;
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                          input int unsigned dcyc, input int unsigned bn, input string name);
    exp_t x;
    x.q = eq; x.r = er; x.dz = edz; x.done_cyc = dcyc; x.busy_n = bn; x.name = name;
    sb.push_back(x);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s.timeout: got no done within 200 cycles required done", name);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                       input string name);
    @(negedge clk);
    a = av;
    b = bv;
`ifdef SIGNED_DIV_EN
    sgn = sv;
`endif
    start = 1'b1;
    push_exp(eq, er, edz, cyc + 1 + ((bv == '0) ? 0 : W), (bv == '0) ? 0 : W, name);
    @(negedge clk);
    start = 1'b0;
    wait_idle(name);
  endtask

  int unsigned d_cyc;
  logic        sv_unused;

  initial begin
    sv_unused = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.busy", {{(W-1){1'b0}}, busy}, '0);
    check("reset.done", {{(W-1){1'b0}}, done}, '0);
    check("reset.dz",   {{(W-1){1'b0}}, dz},   '0);
    check("reset.q", q, '0);
    check("reset.r", r, '0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'd100,        32'd7,          sv_unused, 32'd14,         32'd2,   1'b0, "div_100_7");
    issue(32'hFFFF_FFFF,  32'd1,          sv_unused, 32'hFFFF_FFFF,  32'd0,   1'b0, "div_max_1");
    issue(32'd5,          32'd9,          sv_unused, 32'd0,          32'd5,   1'b0, "div_5_9");
    issue(32'd123,        32'd0,          sv_unused, 32'hFFFF_FFFF,  32'd123, 1'b1, "div_by_zero");
    issue(32'hFFFF_FFFF,  32'hFFFF_FFFE,  sv_unused, 32'd1,          32'd1,   1'b0, "div_big_divisor");
    issue(32'h8000_0000,  32'd3,          sv_unused, 32'h2AAA_AAAA,  32'd2,   1'b0, "div_msb_3");
    issue(32'd1000,       32'd10,         sv_unused, 32'd100,        32'd0,   1'b0, "div_1000_10");

    // start held through the op; operands change mid-CALC.
    @(negedge clk);
    a = 32'd1000;
    b = 32'd7;
    start = 1'b1;
    push_exp(32'd142, 32'd6, 1'b0, cyc + 1 + W, W, "held_first");
    repeat (5) @(negedge clk);
    a = 32'd50;
    b = 32'd6;
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    d_cyc = cyc;
    push_exp(32'd8, 32'd2, 1'b0, d_cyc + 2 + W, W, "held_second");
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_idle("held_second");

    // Reset in the middle of CALC abandons the op.
    @(negedge clk);
    a = 32'd77;
    b = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset.busy", {{(W-1){1'b0}}, busy}, '0);
    check("midreset.done", {{(W-1){1'b0}}, done}, '0);
    check("midreset.q", q, '0);
    check("midreset.r", r, '0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(32'd77, 32'd5, sv_unused, 32'd15, 32'd2, 1'b0, "after_reset");

`ifdef SIGNED_DIV_EN
    issue(32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "signed_m7_2");
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1'b0, "signed_min_m1");
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
